raider_txn_trace: RTL and testbench
===================================

// Module: raider_txn_trace
// PURPOSE
//  Downstream of the host-command decode stage: records each decoded host flash command into a trace FIFO.
//  Each entry holds opcode, 24-bit address, routed flash, active host and a timestamp.
//  The management SPI slave pops entries, so firmware can audit which flash served which access.
//  Single clock domain (system clk); all inputs already synchronised to clk.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of 2, >=2
//  TS_W    16  free-running timestamp width (clk cycles, wraps)
//  ADDR_W  24  captured address width
// PORTS
//  clk            in   1               system clock (50 MHz)
//  rst_n          in   1               reset, synchronous, active-low
//  trace_enable   in   1               1 = capture; 0 = ignore txn_valid (pop/clear still work)
//  txn_valid      in   1               1-cycle strobe: command+address decoded
//  txn_instr      in   8               opcode, qualified by txn_valid
//  txn_addr       in   ADDR_W          address, qualified by txn_valid
//  txn_flash_sel  in   1               0=main flash, 1=secondary flash
//  txn_host_sel   in   1               0=main host, 1=secondary host
//  rd_en          in   1               pop head entry (1-cycle strobe)
//  clear          in   1               flush FIFO and drop counter
//  rd_valid       out  1               FIFO non-empty
//  rd_data        out  TS_W+ADDR_W+10  {ts, host_sel, flash_sel, instr, addr}; head entry
//  level          out  $clog2(DEPTH)+1 entries held
//  drop_cnt       out  8               entries lost to overflow, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - wr/rd pointers=0, level=0, rd_valid=0, rd_data=0, drop_cnt=0, timestamp=0
//   - FIFO storage need not be reset
//  Timestamp: +1 every clk, wraps at 2^TS_W; clear does not reset it.
//  Push: txn_valid & trace_enable & (not full, or pop this cycle).
//   - Stored ts = counter value in the txn_valid cycle.
//  Pop: rd_en & rd_valid; rd_en while empty is ignored, no error.
//  rd_data is show-ahead:
//   - equals head entry whenever rd_valid=1; 0 when empty
//   - a pushed entry is visible one cycle after its txn_valid cycle
//   - after a pop, the next head is visible the following cycle
//  level/rd_valid: registered, updated the cycle after push/pop.
//  Boundary cases:
//   - full, push, no pop: entry dropped; FIFO unchanged; drop_cnt+1, saturates at 255
//   - full, push+pop same cycle: both happen; level stays DEPTH; no drop
//   - empty, push+pop same cycle: pop ignored; push accepted; level=1
//   - clear: pointers/level/drop_cnt=0 next cycle; dominates push/pop in the same cycle
//   - pointers: $clog2(DEPTH) bits plus wrap bit; full = MSBs differ, LSBs equal
//   - trace_enable deasserted: txn_valid ignored; not counted as a drop
//   - reset mid-transaction: all state discarded; no partial entry retained
// CONFIGURATION
//  RAIDER_TRACE_FILTER_EN defined: adds two inputs:
//   - filter_en in 1; filter_opcode in 8
//   - if filter_en=1, only txn_instr==filter_opcode is pushed
//   - non-matching commands are silently ignored (no drop count)
//  Not defined: those ports are absent; every enabled txn_valid is a push candidate.
// TESTING
//  1. Reset, then txn_valid instr=0x03 addr=0x012345 flash=1 host=0 at ts=T
//     -> next cycle rd_valid=1, level=1, rd_data={T,0,1,0x03,0x012345}
//  2. Push 8 entries, then 2 more -> level=8, drop_cnt=2; pop 8 -> entries 1..8 in order, then rd_valid=0
//  3. Full FIFO, txn_valid and rd_en same cycle -> level stays 8, drop_cnt unchanged, oldest entry removed
//  4. Empty FIFO, txn_valid and rd_en same cycle -> level=1, pushed entry readable
//  5. 300 overflow pushes -> drop_cnt=255; then clear with txn_valid same cycle -> level=0, drop_cnt=0
//  6. Filter macro on, filter_en=1, filter_opcode=0x0B; push opcodes 0x03,0x0B,0x02
//     -> only 0x0B stored, drop_cnt=0; macro off -> all three stored

Source files
------------

// File: rtl/raider_txn_trace.sv
`default_nettype none
// ============================================================================
// Module   : raider_txn_trace
// Purpose  : Trace FIFO for decoded host flash commands. Each accepted
//            command is stored as {timestamp, host_sel, flash_sel, opcode,
//            address} so firmware can audit, through the management SPI
//            slave, which flash served which host access.
// Ports    : clk, rst_n (synchronous, active-low)
//            trace_enable, txn_valid, txn_instr, txn_addr,
//            txn_flash_sel, txn_host_sel   - capture side
//            rd_en, clear                  - management side controls
//            rd_valid, rd_data (show-ahead head entry), level, drop_cnt
// Options  : RAIDER_TRACE_FILTER_EN adds filter_en / filter_opcode inputs;
//            when filter_en=1 only txn_instr==filter_opcode is captured.
// Revision : 1.0 - initial release
// ============================================================================
module raider_txn_trace #(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int ADDR_W = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        trace_enable,
    input  logic                        txn_valid,
    input  logic [7:0]                  txn_instr,
    input  logic [ADDR_W-1:0]           txn_addr,
    input  logic                        txn_flash_sel,
    input  logic                        txn_host_sel,
    input  logic                        rd_en,
    input  logic                        clear,
`ifdef RAIDER_TRACE_FILTER_EN
    input  logic                        filter_en,
    input  logic [7:0]                  filter_opcode,
`endif
    output logic                        rd_valid,
    output logic [TS_W+ADDR_W+9:0]      rd_data,
    output logic [$clog2(DEPTH):0]      level,
    output logic [7:0]                  drop_cnt
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_DATA_W = TS_W + ADDR_W + 10;
    localparam logic [c_PTR_W:0] c_ONE = {{c_PTR_W{1'b0}}, 1'b1};

    logic [c_DATA_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0]    r_wr_ptr;
    logic [c_PTR_W:0]    r_rd_ptr;
    logic [c_PTR_W:0]    r_level;
    logic                r_rd_valid;
    logic [7:0]          r_drop_cnt;
    logic [TS_W-1:0]     r_ts;

    logic                w_filter_ok;
    logic                w_cand;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [c_PTR_W:0]    w_level_nxt;
    logic [c_DATA_W-1:0] w_entry;

`ifdef RAIDER_TRACE_FILTER_EN
    assign w_filter_ok = !filter_en || (txn_instr == filter_opcode);
`else
    assign w_filter_ok = 1'b1;
`endif

    // Full when the wrap bits differ and the index bits match.
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_cand  = txn_valid && trace_enable && w_filter_ok;
    // Pop is qualified by the registered non-empty flag, so a pop on an
    // empty FIFO is a no-op even when a push lands in the same cycle.
    assign w_pop   = rd_en && r_rd_valid;
    // A pop frees the slot the push needs, so full+push+pop both proceed.
    assign w_push  = w_cand && (!w_full || w_pop);
    assign w_drop  = w_cand && w_full && !w_pop;
    assign w_entry = {r_ts, txn_host_sel, txn_flash_sel, txn_instr, txn_addr};

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_ONE;
        end
    end

    // Timestamp free-runs; clear deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            r_level    <= w_level_nxt;
            r_rd_valid <= (w_level_nxt != '0);
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_entry;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_valid ? r_mem[r_rd_ptr[c_PTR_W-1:0]] : '0;
    assign level    = r_level;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_raider_txn_trace.sv
`default_nettype none
// ============================================================================
// Module   : tb_raider_txn_trace
// Purpose  : Self-checking bench for raider_txn_trace: directed vector table,
//            hand-written corner sequences and randomized traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raider_txn_trace;

    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int ADDR_W = 24;
    localparam int DW     = TS_W + ADDR_W + 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trace_enable = 1'b0;
    logic              txn_valid = 1'b0;
    logic [7:0]        txn_instr = '0;
    logic [ADDR_W-1:0] txn_addr = '0;
    logic              txn_flash_sel = 1'b0;
    logic              txn_host_sel = 1'b0;
    logic              rd_en = 1'b0;
    logic              clear = 1'b0;
    logic              filter_en = 1'b0;
    logic [7:0]        filter_opcode = '0;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic [3:0]        level;
    logic [7:0]        drop_cnt;

    raider_txn_trace #(.DEPTH(DEPTH), .TS_W(TS_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trace_enable  (trace_enable),
        .txn_valid     (txn_valid),
        .txn_instr     (txn_instr),
        .txn_addr      (txn_addr),
        .txn_flash_sel (txn_flash_sel),
        .txn_host_sel  (txn_host_sel),
        .rd_en         (rd_en),
        .clear         (clear),
`ifdef RAIDER_TRACE_FILTER_EN
        .filter_en     (filter_en),
        .filter_opcode (filter_opcode),
`endif
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .level         (level),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue of entries, timestamp counter, drop counter.
    logic [DW-1:0] m_q[$];
    int            m_ts = 0;
    int            m_drop = 0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] ins;
        logic       re;
        logic       cl;
        int         exp_level;
        int         exp_drop;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic en, input logic v,
                        input logic [7:0] ins, input logic [23:0] ad,
                        input logic fl, input logic hs,
                        input logic re, input logic cl);
        logic cand;
        logic pop;
        int   sz;
        rst_n = rn; trace_enable = en; txn_valid = v; txn_instr = ins;
        txn_addr = ad; txn_flash_sel = fl; txn_host_sel = hs;
        rd_en = re; clear = cl;
        @(posedge clk);
        #1;
        if (!rn) begin
            m_q.delete();
            m_drop = 0;
            m_ts   = 0;
        end else begin
            cand = v && en;
`ifdef RAIDER_TRACE_FILTER_EN
            if (filter_en && (ins != filter_opcode)) cand = 1'b0;
`endif
            sz  = m_q.size();
            pop = re && (sz > 0);
            if (cl) begin
                m_q.delete();
                m_drop = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (cand) begin
                    if (sz < DEPTH || pop)
                        m_q.push_back({m_ts[TS_W-1:0], hs, fl, ins, ad});
                    else if (m_drop < 255)
                        m_drop++;
                end
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
        check("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        check("level",    64'(level),    64'(m_q.size()));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check("rd_data",  64'(rd_data),  (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [7:0] ins, input logic [23:0] ad);
        step(1'b1, 1'b1, 1'b1, ins, ad, ad[0], ad[1], 1'b0, 1'b0);
    endtask

    initial begin
        // en, v, ins, re, cl, level, drop, valid
        vecs[0]  = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1, 0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 8'h0B, 1'b1, 1'b0, 1, 0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1, 0, 1'b1};
        for (int i = 5; i <= 11; i++)
            vecs[i] = '{1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, i - 3, 0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8, 1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 8, 1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 0, 0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 8'h23, 1'b0, 1'b0, 0, 0, 1'b0};

        // Reset state
        do_reset();
        check("reset_level", 64'(level), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);

        // Single capture: timestamp is 0 in the first cycle after reset
        step(1'b1, 1'b1, 1'b1, 8'h03, 24'h012345, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_rd_data", 64'(rd_data),
              64'({16'd0, 1'b0, 1'b1, 8'h03, 24'h012345}));
        check("t1_level", 64'(level), 64'd1);

        // Vector table
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, vecs[i].en, vecs[i].v, vecs[i].ins, 24'(i * 24'h111),
                 1'b0, 1'b1, vecs[i].re, vecs[i].cl);
            check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
            check($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'(vecs[i].exp_drop));
            check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
        end

        // Overflow by two, then drain in order
        do_reset();
        for (int i = 1; i <= 10; i++) push(8'h03, 24'(i));
        check("ovf_level", 64'(level), 64'd8);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", 64'(rd_data[23:0]), 64'(i));
            step(1'b1, 1'b1, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("drain_empty", 64'(rd_valid), 64'd0);

        // Drop counter saturation, then clear beats a simultaneous push
        do_reset();
        for (int i = 0; i < 308; i++) push(8'h02, 24'(i));
        check("sat_drop", 64'(drop_cnt), 64'd255);
        step(1'b1, 1'b1, 1'b1, 8'h02, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_level", 64'(level), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);

        // Opcode filter
        do_reset();
        filter_en = 1'b1;
        filter_opcode = 8'h0B;
        push(8'h03, 24'h000100);
        push(8'h0B, 24'h000200);
        push(8'h02, 24'h000300);
`ifdef RAIDER_TRACE_FILTER_EN
        check("filt_level", 64'(level), 64'd1);
        check("filt_head", 64'(rd_data[31:24]), 64'h0B);
`else
        check("filt_level", 64'(level), 64'd3);
        check("filt_head", 64'(rd_data[31:24]), 64'h03);
`endif
        check("filt_drop", 64'(drop_cnt), 64'd0);
        filter_en = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom), 24'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
